// File: rtl/image_mem_arbiter.sv
// image_mem_arbiter
//   Shares one single-port image RAM among NUM_REQ requesters. The grant is
//   decided combinationally in the request cycle with round-robin priority.
//   A requester can hold a lock so that its burst is not broken up. Read data
//   is returned one cycle after the grant to the requester that issued it.
//
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   req/req_we/req_lock  : per-requester request, write(1)/read(0), keep-grant
//   req_addr/req_data    : flattened per-requester address and write data
//   gnt                  : one-hot grant; the access completes this cycle
//   rvalid/rdata         : one-hot read-return strobe and shared read data
//   addr_err             : pulse one cycle after an out-of-range access
//   ram_addr/ram_data/ram_wren/ram_q : direct RAM connection (q is 1-cycle)
module image_mem_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_SZ   = 15,
  parameter int COL_SZ    = 3,
  parameter int MEM_DEPTH = 19200
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ*ADDR_SZ-1:0] req_addr,
  input  logic [NUM_REQ*COL_SZ-1:0]  req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rvalid,
  output logic [COL_SZ-1:0]          rdata,
  output logic                       addr_err,
  output logic [ADDR_SZ-1:0]         ram_addr,
  output logic [COL_SZ-1:0]          ram_data,
  output logic                       ram_wren,
  input  logic [COL_SZ-1:0]          ram_q
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [ADDR_SZ:0] DEPTH_C = (ADDR_SZ+1)'(MEM_DEPTH);

  logic [PTR_W-1:0]   r_last_ptr_p1;
  logic [PTR_W-1:0]   r_lock_owner_p1;
  logic               r_lock_active_p1;
  logic [NUM_REQ-1:0] r_rd_pend_p1;
  logic               r_err_p1;

  logic               w_lock_hit_p0;
  logic               w_vld_p0;
  logic [PTR_W-1:0]   w_gidx_p0;
  logic [NUM_REQ-1:0] w_gnt_p0;
  logic [ADDR_SZ-1:0] w_addr_p0;
  logic [COL_SZ-1:0]  w_data_p0;
  logic               w_we_p0;
  logic               w_lock_p0;
  logic               w_inrange_p0;

  // ---- stage p0: grant selection and RAM drive (combinational) ----
  always_comb begin
    int best_d;
    int d;
    w_lock_hit_p0 = 1'b0;
    w_vld_p0      = 1'b0;
    w_gidx_p0     = '0;
    best_d        = NUM_REQ;
    d             = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_lock_active_p1 && (r_lock_owner_p1 == PTR_W'(i)) && req[i])
        w_lock_hit_p0 = 1'b1;
    end
    if (w_lock_hit_p0) begin
      w_vld_p0  = 1'b1;
      w_gidx_p0 = r_lock_owner_p1;
    end else begin
      // Distance from the slot just after last_ptr; the closest requester wins.
      for (int i = 0; i < NUM_REQ; i++) begin
        d = (i + 2*NUM_REQ - int'(r_last_ptr_p1) - 1) % NUM_REQ;
        if (req[i] && (d < best_d)) begin
          best_d    = d;
          w_vld_p0  = 1'b1;
          w_gidx_p0 = PTR_W'(i);
        end
      end
    end
    // Nothing is granted while reset is held, even if requests are present.
    if (!resetn)
      w_vld_p0 = 1'b0;
  end

  always_comb begin
    w_gnt_p0  = '0;
    w_addr_p0 = '0;
    w_data_p0 = '0;
    w_we_p0   = 1'b0;
    w_lock_p0 = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_vld_p0 && (w_gidx_p0 == PTR_W'(i))) begin
        w_gnt_p0[i] = 1'b1;
        w_addr_p0   = req_addr[i*ADDR_SZ +: ADDR_SZ];
        w_data_p0   = req_data[i*COL_SZ +: COL_SZ];
        w_we_p0     = req_we[i];
        w_lock_p0   = req_lock[i];
      end
    end
  end

  assign w_inrange_p0 = ({1'b0, w_addr_p0} < DEPTH_C);

  assign gnt      = w_gnt_p0;
  assign ram_addr = w_addr_p0;
  assign ram_data = w_data_p0;
  assign ram_wren = w_vld_p0 & w_we_p0 & w_inrange_p0;

  // ---- stage p1: arbitration state and in-flight read tracking ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_ptr_p1    <= PTR_W'(NUM_REQ-1);
      r_lock_owner_p1  <= '0;
      r_lock_active_p1 <= 1'b0;
      r_rd_pend_p1     <= '0;
      r_err_p1         <= 1'b0;
    end else begin
      if (w_vld_p0) begin
        r_last_ptr_p1   <= w_gidx_p0;
        r_lock_owner_p1 <= w_gidx_p0;
      end
      // An idle cycle for the owner (no grant to it) always drops the lock.
      r_lock_active_p1 <= w_vld_p0 & w_lock_p0;
      r_rd_pend_p1     <= (w_vld_p0 && !w_we_p0) ? w_gnt_p0 : '0;
      r_err_p1         <= w_vld_p0 & ~w_inrange_p0;
    end
  end

  assign rvalid   = r_rd_pend_p1;
  assign addr_err = r_err_p1;
  assign rdata    = ((|r_rd_pend_p1) && !r_err_p1) ? ram_q : '0;

endmodule

// File: tb/tb_image_mem_arbiter.sv
module tb_image_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 15;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic [N-1:0]      req, req_we, req_lock;
  logic [N*AW-1:0]   req_addr;
  logic [N*CW-1:0]   req_data;
  logic [N-1:0]      gnt, rvalid;
  logic [CW-1:0]     rdata;
  logic              addr_err;
  logic [AW-1:0]     ram_addr;
  logic [CW-1:0]     ram_data;
  logic              ram_wren;
  logic [CW-1:0]     ram_q;

  // RAM model: registered address, q one cycle later; preload port for setup.
  logic [CW-1:0]     mem [0:32767];
  logic              pl_we;
  logic [AW-1:0]     pl_addr;
  logic [CW-1:0]     pl_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we)
      mem[pl_addr] <= pl_data;
    else if (ram_wren)
      mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  image_mem_arbiter #(.NUM_REQ(N), .ADDR_SZ(AW), .COL_SZ(CW), .MEM_DEPTH(19200)) dut (
    .clk(clk), .resetn(resetn),
    .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .addr_err(addr_err),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic lk,
                         input logic [AW-1:0] a, input logic [CW-1:0] d);
    req[i]                = 1'b1;
    req_we[i]             = we;
    req_lock[i]           = lk;
    req_addr[i*AW +: AW]  = a;
    req_data[i*CW +: CW]  = d;
  endtask

  task automatic drop(input int i);
    req[i]      = 1'b0;
    req_lock[i] = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [CW-1:0] d);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_we   = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    #4;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
    total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL rst_rvalid got=%b exp=0000", rvalid); end
    total++; if (rdata !== 3'd0) begin bad++; $display("FAIL rst_rdata got=%0d exp=0", rdata); end
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL rst_addr_err got=%b exp=0", addr_err); end
    total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL rst_wren got=%b exp=0", ram_wren); end
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_single_read();
    set_req(2, 1'b0, 1'b0, 15'd100, 3'd0);
    #4;
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL rd_gnt got=%b exp=0100", gnt); end
    total++; if (ram_addr !== 15'd100) begin bad++; $display("FAIL rd_addr got=%0d exp=100", ram_addr); end
    total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL rd_wren got=%b exp=0", ram_wren); end
    tick();
    drop(2);
    #4;
    total++; if (rvalid !== 4'b0100) begin bad++; $display("FAIL rd_rvalid got=%b exp=0100", rvalid); end
    total++; if (rdata !== 3'd5) begin bad++; $display("FAIL rd_rdata got=%0d exp=5", rdata); end
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rd_idle_gnt got=%b exp=0000", gnt); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic [3:0] ev;
    logic [2:0] ed;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 15'(10 + i), 3'd0);
    for (int k = 0; k < 5; k++) begin
      #4;
      eg = 4'b0001 << (k % 4);
      total++; if (gnt !== eg) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, gnt, eg); end
      if (k > 0) begin
        ev = 4'b0001 << ((k - 1) % 4);
        ed = 3'(((k - 1) % 4) + 1);
        total++; if (rvalid !== ev) begin bad++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", k, rvalid, ev); end
        total++; if (rdata !== ed) begin bad++; $display("FAIL rr_rdata[%0d] got=%0d exp=%0d", k, rdata, ed); end
      end
      tick();
    end
    for (int i = 0; i < N; i++) drop(i);
    #4;
    total++; if (rvalid !== 4'b0001) begin bad++; $display("FAIL rr_last_rvalid got=%b exp=0001", rvalid); end
    total++; if (rdata !== 3'd1) begin bad++; $display("FAIL rr_last_rdata got=%0d exp=1", rdata); end
    tick();
  endtask

  task automatic test_write_read();
    set_req(3, 1'b1, 1'b0, 15'd19199, 3'd6);
    #4;
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL wr_gnt got=%b exp=1000", gnt); end
    total++; if (ram_wren !== 1'b1) begin bad++; $display("FAIL wr_wren got=%b exp=1", ram_wren); end
    total++; if (ram_addr !== 15'd19199) begin bad++; $display("FAIL wr_addr got=%0d exp=19199", ram_addr); end
    total++; if (ram_data !== 3'd6) begin bad++; $display("FAIL wr_data got=%0d exp=6", ram_data); end
    tick();
    drop(3);
    set_req(1, 1'b0, 1'b0, 15'd19199, 3'd0);
    #4;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL wr_rd_gnt got=%b exp=0010", gnt); end
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL wr_addr_err got=%b exp=0", addr_err); end
    tick();
    drop(1);
    #4;
    total++; if (rvalid !== 4'b0010) begin bad++; $display("FAIL wr_rd_rvalid got=%b exp=0010", rvalid); end
    total++; if (rdata !== 3'd6) begin bad++; $display("FAIL wr_rd_rdata got=%0d exp=6", rdata); end
    tick();
  endtask

  task automatic test_lock();
    set_req(1, 1'b0, 1'b0, 15'd200, 3'd0);
    for (int j = 0; j < 3; j++) begin
      set_req(0, 1'b1, 1'b1, 15'(200 + j), 3'(j + 1));
      #4;
      total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL lock_gnt[%0d] got=%b exp=0001", j, gnt); end
      total++; if (ram_wren !== 1'b1) begin bad++; $display("FAIL lock_wren[%0d] got=%b exp=1", j, ram_wren); end
      total++; if (ram_addr !== 15'(200 + j)) begin bad++; $display("FAIL lock_addr[%0d] got=%0d exp=%0d", j, ram_addr, 200 + j); end
      tick();
    end
    drop(0);
    #4;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL lock_release_gnt got=%b exp=0010", gnt); end
    total++; if (ram_addr !== 15'd200) begin bad++; $display("FAIL lock_release_addr got=%0d exp=200", ram_addr); end
    tick();
    drop(1);
    #4;
    total++; if (rvalid !== 4'b0010) begin bad++; $display("FAIL lock_rvalid got=%b exp=0010", rvalid); end
    total++; if (rdata !== 3'd1) begin bad++; $display("FAIL lock_rdata got=%0d exp=1", rdata); end
    tick();
  endtask

  task automatic test_oor();
    set_req(1, 1'b1, 1'b0, 15'd19200, 3'd7);
    #4;
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL oor_wr_gnt got=%b exp=0010", gnt); end
    total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL oor_wr_wren got=%b exp=0", ram_wren); end
    tick();
    set_req(1, 1'b0, 1'b0, 15'd19200, 3'd0);
    #4;
    total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL oor_wr_err got=%b exp=1", addr_err); end
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL oor_rd_gnt got=%b exp=0010", gnt); end
    total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL oor_rd_wren got=%b exp=0", ram_wren); end
    tick();
    drop(1);
    #4;
    total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL oor_rd_err got=%b exp=1", addr_err); end
    total++; if (rvalid !== 4'b0010) begin bad++; $display("FAIL oor_rvalid got=%b exp=0010", rvalid); end
    total++; if (rdata !== 3'd0) begin bad++; $display("FAIL oor_rdata got=%0d exp=0", rdata); end
    total++; if (mem[19200] !== 3'd3) begin bad++; $display("FAIL oor_mem got=%0d exp=3", mem[19200]); end
    tick();
    #4;
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL oor_err_clear got=%b exp=0", addr_err); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    set_req(2, 1'b0, 1'b0, 15'd100, 3'd0);
    #4;
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL mid_gnt got=%b exp=0100", gnt); end
    #1;
    resetn = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL mid_rst_gnt got=%b exp=0000", gnt); end
    total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL mid_rst_rvalid got=%b exp=0000", rvalid); end
    tick();
    #4;
    total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL mid_after_rvalid got=%b exp=0000", rvalid); end
    total++; if (rdata !== 3'd0) begin bad++; $display("FAIL mid_after_rdata got=%0d exp=0", rdata); end
    tick();
    resetn = 1'b1;
    set_req(0, 1'b0, 1'b0, 15'd10, 3'd0);
    #4;
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL mid_prio_gnt got=%b exp=0001", gnt); end
    total++; if (rvalid !== 4'b0000) begin bad++; $display("FAIL mid_prio_rvalid got=%b exp=0000", rvalid); end
    tick();
    drop(0);
    drop(2);
    #4;
    total++; if (rvalid !== 4'b0001) begin bad++; $display("FAIL mid_final_rvalid got=%b exp=0001", rvalid); end
    total++; if (rdata !== 3'd1) begin bad++; $display("FAIL mid_final_rdata got=%0d exp=1", rdata); end
    tick();
  endtask

  initial begin
    resetn   = 1'b0;
    req      = '0;
    req_we   = '0;
    req_lock = '0;
    req_addr = '0;
    req_data = '0;
    pl_we    = 1'b0;
    pl_addr  = '0;
    pl_data  = '0;
    tick();
    preload(15'd100,   3'd5);
    preload(15'd10,    3'd1);
    preload(15'd11,    3'd2);
    preload(15'd12,    3'd3);
    preload(15'd13,    3'd4);
    preload(15'd19199, 3'd2);
    preload(15'd19200, 3'd3);
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_read();
    test_lock();
    test_oor();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
